// File: rtl/junction_pkg.sv
// junction_pkg: shared phase encoding and country light constants for the
// junction timer. Optional build macro used by the top: JUNCTION_TIMER_EARLY_END_EN.
package junction_pkg;

    // Phase encoding as seen on the phase output.
    typedef enum logic [1:0] {
        HWY_GREEN  = 2'd0,
        HWY_YELLOW = 2'd1,
        CR_GREEN   = 2'd2,
        CR_YELLOW  = 2'd3
    } phase_e;

    // Country light, one-hot {green, yellow, red}.
    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    // Country light shown for a given phase; the highway phases keep it red.
    function automatic logic [2:0] country_led_for(input logic [1:0] ph);
        logic [2:0] led;
        case (ph)
            CR_GREEN:  led = GREEN;
            CR_YELLOW: led = YELLOW;
            default:   led = RED;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/junction_timer_phase_counter.sv
// phase_counter: 4-bit phase counter with load, guarded decrement and
// saturating increment. Priority is load, then decrement, then increment,
// so the counter can never wrap below 0 or above SAT_MAX.
module phase_counter
    import junction_pkg::*;
#(
    parameter logic [3:0] SAT_MAX = 4'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    input  logic       inc_i,
    output logic [3:0] count_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: load wins, decrement stops at 0, increment stops at SAT_MAX.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            if (count_q != 4'd0) begin
                count_d = count_q - 4'd1;
            end
        end else if (inc_i) begin
            if (count_q < SAT_MAX) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/junction_timer.sv
// junction_timer: highway / country road junction sequencer.
// Highway green runs at least T_HWY cycles and only yields to a waiting
// country car; yellow lasts T_Y on either road; country green lasts T_CR.
// Build macro JUNCTION_TIMER_EARLY_END_EN: when defined, country green ends
// early (into country yellow) as soon as the sensor reports no car.
module junction_timer
    import junction_pkg::*;
#(
    parameter int T_HWY = 10,
    parameter int T_Y   = 3,
    parameter int T_CR  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    output logic [3:0] hwy_count,
    output logic [3:0] cr_count,
    output logic [2:0] country_led,
    output logic [1:0] phase
);

    localparam logic [1:0] ST_HWY_GREEN  = 2'd0;
    localparam logic [1:0] ST_HWY_YELLOW = 2'd1;
    localparam logic [1:0] ST_CR_GREEN   = 2'd2;
    localparam logic [1:0] ST_CR_YELLOW  = 2'd3;

    localparam logic [3:0] HWY_LEN = 4'(T_HWY);
    localparam logic [3:0] Y_LEN   = 4'(T_Y);
    localparam logic [3:0] CR_LEN  = 4'(T_CR);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] led_q;

    logic       hwy_load;
    logic [3:0] hwy_val;
    logic       hwy_dec;
    logic       hwy_inc;
    logic       cr_load;
    logic [3:0] cr_val;
    logic       cr_dec;
    logic       early_exit;

`ifdef JUNCTION_TIMER_EARLY_END_EN
    // No car on the country road: cut country green short.
    assign early_exit = !sensor;
`else
    // Country green always runs its full length.
    assign early_exit = 1'b0;
`endif

    // Phase sequencing and counter control. The idle count of each phase is
    // held at 0 by an explicit load so the two counts never overlap.
    always_comb begin
        state_d  = state_q;
        hwy_load = 1'b0;
        hwy_val  = 4'd0;
        hwy_dec  = 1'b0;
        hwy_inc  = 1'b0;
        cr_load  = 1'b0;
        cr_val   = 4'd0;
        cr_dec   = 1'b0;
        case (state_q)
            ST_HWY_GREEN: begin
                cr_load = 1'b1;
                if (hwy_count == HWY_LEN && sensor) begin
                    state_d  = ST_HWY_YELLOW;
                    hwy_load = 1'b1;
                    hwy_val  = Y_LEN;
                end else begin
                    hwy_inc = 1'b1;
                end
            end
            ST_HWY_YELLOW: begin
                // Committed: the sensor is not consulted here.
                cr_load = 1'b1;
                if (hwy_count <= 4'd1) begin
                    state_d  = ST_CR_GREEN;
                    hwy_load = 1'b1;
                    cr_val   = CR_LEN;
                end else begin
                    hwy_dec = 1'b1;
                end
            end
            ST_CR_GREEN: begin
                hwy_load = 1'b1;
                // Timeout and early exit lead to the same place with T_Y.
                if (cr_count <= 4'd1 || early_exit) begin
                    state_d = ST_CR_YELLOW;
                    cr_load = 1'b1;
                    cr_val  = Y_LEN;
                end else begin
                    cr_dec = 1'b1;
                end
            end
            default: begin
                hwy_load = 1'b1;
                if (cr_count <= 4'd1) begin
                    state_d = ST_HWY_GREEN;
                    cr_load = 1'b1;
                end else begin
                    cr_dec = 1'b1;
                end
            end
        endcase
    end

    // State and country light registers; the light follows the next state so
    // both change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HWY_GREEN;
            led_q   <= RED;
        end else begin
            state_q <= state_d;
            led_q   <= country_led_for(state_d);
        end
    end

    phase_counter #(
        .SAT_MAX (HWY_LEN)
    ) u_hwy_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (hwy_load),
        .load_val_i (hwy_val),
        .dec_i      (hwy_dec),
        .inc_i      (hwy_inc),
        .count_o    (hwy_count)
    );

    phase_counter #(
        .SAT_MAX (4'd15)
    ) u_cr_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cr_load),
        .load_val_i (cr_val),
        .dec_i      (cr_dec),
        .inc_i      (1'b0),
        .count_o    (cr_count)
    );

    assign country_led = led_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_junction_timer.sv
// tb_junction_timer: directed, table-driven bench for junction_timer with
// default parameters. Expectations follow the build macro
// JUNCTION_TIMER_EARLY_END_EN when it is defined.
module tb_junction_timer;

  logic       clk;
  logic       rst_n;
  logic       sensor;
  logic [3:0] hwy_count;
  logic [3:0] cr_count;
  logic [2:0] country_led;
  logic [1:0] phase;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       sensor;
    logic [1:0] phase;
    logic [3:0] hwy;
    logic [3:0] cr;
    logic [2:0] led;
  } vec_t;

  vec_t vecs[$];

  junction_timer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor      (sensor),
    .hwy_count   (hwy_count),
    .cr_count    (cr_count),
    .country_led (country_led),
    .phase       (phase)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ph, input logic [3:0] hw,
                           input logic [3:0] cr, input logic [2:0] led);
    check({tag, ".phase"}, int'(phase), int'(ph));
    check({tag, ".hwy"}, int'(hwy_count), int'(hw));
    check({tag, ".cr"}, int'(cr_count), int'(cr));
    check({tag, ".led"}, int'(country_led), int'(led));
  endtask

  // drive sensor, take one edge, sample 1 time unit later
  task automatic step(input logic s);
    sensor = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [1:0] ph, input logic [3:0] hw,
                     input logic [3:0] cr, input logic [2:0] led);
    vec_t v;
    v.sensor = s; v.phase = ph; v.hwy = hw; v.cr = cr; v.led = led;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // full cycle with sensor held 1: expected state after each edge
    for (int i = 1; i <= 10; i++) add(1'b1, 2'd0, 4'(i), 4'd0, 3'b001);
    for (int i = 3; i >= 1; i--)  add(1'b1, 2'd1, 4'(i), 4'd0, 3'b001);
    for (int i = 5; i >= 1; i--)  add(1'b1, 2'd2, 4'd0, 4'(i), 3'b100);
    for (int i = 3; i >= 1; i--)  add(1'b1, 2'd3, 4'd0, 4'(i), 3'b010);
    add(1'b1, 2'd0, 4'd0, 4'd0, 3'b001);
    add(1'b1, 2'd0, 4'd1, 4'd0, 3'b001);

    // reset state
    rst_n  = 1'b0;
    sensor = 1'b0;
    #12;
    check_all("reset", 2'd0, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven full cycle
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sensor);
      check_all($sformatf("cycle[%0d]", i), vecs[i].phase, vecs[i].hwy, vecs[i].cr, vecs[i].led);
    end

    // sensor low for 40 cycles: hold highway green, count saturates at 10
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      check_all($sformatf("idle[%0d]", i), 2'd0, 4'((i + 2 > 10) ? 10 : i + 2), 4'd0, 3'b001);
    end

    // sensor drops on the second yellow cycle: yellow still completes
    step(1'b1);
    check_all("ydrop.y3", 2'd1, 4'd3, 4'd0, 3'b001);
    step(1'b0);
    check_all("ydrop.y2", 2'd1, 4'd2, 4'd0, 3'b001);
    step(1'b0);
    check_all("ydrop.y1", 2'd1, 4'd1, 4'd0, 3'b001);
    step(1'b0);
    check_all("ydrop.crg5", 2'd2, 4'd0, 4'd5, 3'b100);

    // early end: car present for one more edge, then leaves at cr_count=4
    step(1'b1);
    check_all("early.crg4", 2'd2, 4'd0, 4'd4, 3'b100);
`ifdef JUNCTION_TIMER_EARLY_END_EN
    step(1'b0);
    check_all("early.cry3", 2'd3, 4'd0, 4'd3, 3'b010);
`else
    for (int i = 3; i >= 1; i--) begin
      step(1'b0);
      check_all($sformatf("full.crg%0d", i), 2'd2, 4'd0, 4'(i), 3'b100);
    end
    step(1'b0);
    check_all("full.cry3", 2'd3, 4'd0, 4'd3, 3'b010);
`endif
    step(1'b0);
    check_all("tail.cry2", 2'd3, 4'd0, 4'd2, 3'b010);
    step(1'b0);
    check_all("tail.cry1", 2'd3, 4'd0, 4'd1, 3'b010);
    step(1'b0);
    check_all("tail.hg0", 2'd0, 4'd0, 4'd0, 3'b001);

    // run to country green cr_count=2, then reset between edges
    for (int i = 0; i < 10; i++) step(1'b1);   // hwy 1..10
    step(1'b1);                                 // yellow 3
    step(1'b1);                                 // 2
    step(1'b1);                                 // 1
    step(1'b1);                                 // cr 5
    step(1'b1);                                 // 4
    step(1'b1);                                 // 3
    step(1'b1);                                 // 2
    check_all("prerst", 2'd2, 4'd0, 4'd2, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst", 2'd0, 4'd0, 4'd0, 3'b001);
    @(posedge clk);
    #1;
    check_all("rsthold", 2'd0, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    check_all("postrst", 2'd0, 4'd1, 4'd0, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
